ps2_keyboard_rx: RTL and testbench

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_frame_rx.sv | 128 ++++++++++++
 rtl/ps2_keyboard_rx.sv | 76 +++++++
 tb/tb_ps2_keyboard_rx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
//   - ps2_state_e : frame FSM state encoding
//   - PREFIX_EXT  : extended-key prefix byte (0xE0)
//   - PREFIX_REL  : break/release prefix byte (0xF0)
//   - FILTER_LEN_DEFAULT / TIMEOUT_DEFAULT : default parameter values
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } ps2_state_e;

  localparam logic [7:0]  PREFIX_EXT         = 8'hE0;
  localparam logic [7:0]  PREFIX_REL         = 8'hF0;
  localparam int unsigned FILTER_LEN_DEFAULT = 8;
  localparam int unsigned TIMEOUT_DEFAULT    = 20000;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: line synchronizers, clock glitch filter, 11-bit frame FSM
// and inter-edge timeout.
//   i_clk, i_reset     : system clock, synchronous active-high reset
//   i_ps2_clk/i_ps2_data : raw PS/2 lines (asynchronous)
//   o_rx_byte          : last correctly received byte
//   o_rx_byte_valid    : one-cycle pulse, o_rx_byte is new
//   o_frame_err        : one-cycle pulse on parity, stop-bit or timeout failure
//   o_busy             : high while the FSM is not idle
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_byte_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_filt, r_filt_prev;
  logic [FW-1:0] r_filt_cnt;
  logic          w_fall;

  // Synchronizers and filter; the filtered clock flips only after FILTER_LEN
  // consecutive samples disagree with it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_filt      <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_s1    <= i_ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= i_ps2_data;
      r_dat_s2    <= r_dat_s1;
      r_filt_prev <= r_filt;
      if (r_clk_s2 != r_filt) begin
        if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
          r_filt     <= r_clk_s2;
          r_filt_cnt <= '0;
        end else begin
          r_filt_cnt <= r_filt_cnt + 1'b1;
        end
      end else begin
        r_filt_cnt <= '0;
      end
    end
  end

  assign w_fall = r_filt_prev & ~r_filt;

  ps2_state_e    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= StIdle;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_parity        <= 1'b0;
      r_to_cnt        <= '0;
      o_rx_byte       <= '0;
      o_rx_byte_valid <= 1'b0;
      o_frame_err     <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      o_rx_byte_valid <= 1'b0;
      o_frame_err     <= 1'b0;
      if (r_state == StIdle) begin
        r_to_cnt <= '0;
        if (w_fall && !r_dat_s2) begin
          r_state   <= StData;
          r_bit_cnt <= '0;
          o_busy    <= 1'b1;
        end
      end else if (w_fall) begin
        // An edge coinciding with expiry takes priority over the timeout.
        r_to_cnt <= '0;
        unique case (r_state)
          StData: begin
            r_shift <= {r_dat_s2, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) r_state <= StParity;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          StParity: begin
            r_parity <= r_dat_s2;
            r_state  <= StStop;
          end
          StStop: begin
            r_state <= StIdle;
            o_busy  <= 1'b0;
            if (r_dat_s2 && (^{r_shift, r_parity})) begin
              o_rx_byte       <= r_shift;
              o_rx_byte_valid <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
        r_state     <= StIdle;
        r_to_cnt    <= '0;
        o_busy      <= 1'b0;
        o_frame_err <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver top: frame receiver plus scan-code prefix decoder.
//   i_clk, i_reset        : system clock, synchronous active-high reset
//   io_ps2_clk/io_ps2_data : PS/2 lines, never driven (high-Z)
//   o_rx_byte, o_rx_byte_valid : raw received bytes
//   o_key_code, o_key_extended, o_key_release, o_key_valid : decoded key event
//   o_frame_err, o_busy   : frame error pulse, receiver busy
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEFAULT,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  inout  wire        io_ps2_clk,
  inout  wire        io_ps2_data,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_byte_valid,
  output logic [7:0] o_key_code,
  output logic       o_key_extended,
  output logic       o_key_release,
  output logic       o_key_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  assign io_ps2_clk  = 1'bz;
  assign io_ps2_data = 1'bz;

  ps2_frame_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_frame (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_ps2_clk      (io_ps2_clk),
    .i_ps2_data     (io_ps2_data),
    .o_rx_byte      (o_rx_byte),
    .o_rx_byte_valid(o_rx_byte_valid),
    .o_frame_err    (o_frame_err),
    .o_busy         (o_busy)
  );

  logic r_ext, r_rel;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ext          <= 1'b0;
      r_rel          <= 1'b0;
      o_key_code     <= '0;
      o_key_extended <= 1'b0;
      o_key_release  <= 1'b0;
      o_key_valid    <= 1'b0;
    end else begin
      o_key_valid <= 1'b0;
      if (o_frame_err) begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end else if (o_rx_byte_valid) begin
        if (o_rx_byte == PREFIX_EXT) begin
          r_ext <= 1'b1;
        end else if (o_rx_byte == PREFIX_REL) begin
          r_rel <= 1'b1;
        end else begin
          o_key_code     <= o_rx_byte;
          o_key_extended <= r_ext;
          o_key_release  <= r_rel;
          o_key_valid    <= 1'b1;
          r_ext          <= 1'b0;
          r_rel          <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
module tb_ps2_keyboard_rx;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TIMEOUT    = 2000;
  localparam int          HALF       = 20;  // PS/2 half-period in system clocks

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       drv_clk = 1'b1;
  logic       drv_dat = 1'b1;
  wire        ps2_clk;
  wire        ps2_data;
  logic [7:0] rx_byte, key_code;
  logic       rx_byte_valid, key_extended, key_release, key_valid, frame_err, busy;

  assign ps2_clk  = drv_clk;
  assign ps2_data = drv_dat;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .io_ps2_clk     (ps2_clk),
    .io_ps2_data    (ps2_data),
    .o_rx_byte      (rx_byte),
    .o_rx_byte_valid(rx_byte_valid),
    .o_key_code     (key_code),
    .o_key_extended (key_extended),
    .o_key_release  (key_release),
    .o_key_valid    (key_valid),
    .o_frame_err    (frame_err),
    .o_busy         (busy)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] q_rx[$];
  key_t       q_key[$];
  int         exp_err = 0;
  bit         m_ext = 0, m_rel = 0;  // reference decoder flags

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what a frame should produce, decided from the frame contents.
  task automatic expect_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    if (bad_par || bad_stop) begin
      exp_err++;
      m_ext = 0;
      m_rel = 0;
    end else begin
      q_rx.push_back(b);
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_rel = 1;
      else begin
        q_key.push_back('{code: b, ext: m_ext, rel: m_rel});
        m_ext = 0;
        m_rel = 0;
      end
    end
  endtask

  task automatic ps2_bit(input logic d);
    drv_dat = d;
    repeat (HALF) @(posedge clk);
    drv_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    drv_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    expect_frame(b, bad_par, bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(~bad_stop);
    drv_dat = 1'b1;
    repeat (3 * HALF) @(posedge clk);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output pulse.
  logic [7:0] m_last_rx = 8'h00;
  logic       prev_rxv = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        m_last_rx = 8'h00;
      end else begin
        if (rx_byte_valid) begin
          if (q_rx.size() == 0) chk("unexpected_rx_byte_valid", {24'd0, rx_byte}, 32'hFFFF);
          else begin
            m_last_rx = q_rx.pop_front();
            chk("rx_byte", {24'd0, rx_byte}, {24'd0, m_last_rx});
          end
        end
        if (key_valid) begin
          chk("key_valid_latency", {31'd0, prev_rxv}, 32'd1);
          if (q_key.size() == 0) chk("unexpected_key_valid", {24'd0, key_code}, 32'hFFFF);
          else begin
            key_t k;
            k = q_key.pop_front();
            chk("key_event", {22'd0, key_code, key_extended, key_release},
                {22'd0, k.code, k.ext, k.rel});
          end
        end
        if (frame_err) begin
          if (exp_err == 0) chk("unexpected_frame_err", 32'd1, 32'd0);
          else begin
            exp_err--;
            chk("rx_byte_hold_on_err", {24'd0, rx_byte}, {24'd0, m_last_rx});
          end
        end
      end
      prev_rxv = rx_byte_valid;
    end
  end

  task automatic check_idle_outputs(input string name);
    @(negedge clk);
    chk(name, {rx_byte, key_code, 10'd0, rx_byte_valid, key_valid, key_extended,
               key_release, frame_err, busy}, 32'd0);
  endtask

  task automatic drain(input string name);
    repeat (4 * HALF) @(posedge clk);
    chk(name, q_rx.size() + q_key.size() + exp_err, 0);
  endtask

  initial begin
    logic [7:0] b;
    bit bp, bs;
    repeat (5) @(posedge clk);
    check_idle_outputs("reset_state");
    reset = 1'b0;
    repeat (5) @(posedge clk);
    check_idle_outputs("after_reset_state");

    // Plain make code, break code, extended break.
    send_frame(8'h1C, 0, 0);
    drain("single_1C");
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    drain("break_1C");
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    send_frame(8'h1C, 0, 0);
    drain("ext_break_75");

    // Parity error clears a pending F0.
    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 1, 0);
    send_frame(8'h1C, 0, 0);
    drain("parity_err");
    send_frame(8'h33, 0, 1);
    drain("stop_err");

    // Clock stall after 4 data bits.
    m_ext = 0;
    m_rel = 0;
    exp_err++;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    @(negedge clk);
    chk("busy_mid_frame", {31'd0, busy}, 32'd1);
    repeat (TIMEOUT + 10) @(posedge clk);
    @(negedge clk);
    chk("busy_after_timeout", {31'd0, busy}, 32'd0);
    send_frame(8'h29, 0, 0);
    drain("after_timeout_29");

    // Short low glitch with data low must not start a frame.
    drv_dat = 1'b0;
    drv_clk = 1'b0;
    repeat (3) @(posedge clk);
    drv_clk = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("glitch_busy", {31'd0, busy}, 32'd0);
    end
    drv_dat = 1'b1;
    repeat (HALF) @(posedge clk);

    // Reset during bit 5 with a pending F0 flag.
    send_frame(8'hF0, 0, 0);
    drain("pre_reset_F0");
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(i[0]);
    drv_dat = 1'b1;
    repeat (HALF / 2) @(posedge clk);
    drv_clk = 1'b0;
    repeat (HALF / 2) @(posedge clk);
    reset = 1'b1;
    drv_clk = 1'b1;
    m_ext = 0;
    m_rel = 0;
    repeat (2) @(posedge clk);
    check_idle_outputs("mid_frame_reset");
    repeat (20) @(posedge clk);
    reset = 1'b0;
    repeat (HALF) @(posedge clk);
    send_frame(8'h1C, 0, 0);
    drain("after_reset_1C");

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 15) == 0);
      send_frame(b, bp, bs);
    end
    drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
